// File: rtl/eth_rx_frame_ctrl_if.sv
// Consumer-side frame handshake and random-access read port of the GMII RX frame controller.
interface eth_rx_frame_ctrl_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              frame_valid;
    logic [ADDR_W-1:0] frame_len;
    logic              frame_bank;
    logic              frame_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    modport master (
        output frame_valid, frame_len, frame_bank, rd_data,
        input  frame_ack, rd_addr
    );

    modport slave (
        input  frame_valid, frame_len, frame_bank, rd_data,
        output frame_ack, rd_addr
    );
endinterface

// File: rtl/eth_rx_frame_ctrl.sv
// GMII RX capture from PHY#1 into a two-bank frame buffer: strips preamble/SFD,
// validates length and rx_er, and hands each good frame to one consumer.
module eth_rx_frame_ctrl #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic                      phy1_rx_clk,
    input  logic                      rst_n,
    input  logic                      phy1_rx_dv_i,
    input  logic                      phy1_rx_er_i,
    input  logic [7:0]                phy1_rx_data_i,
    eth_rx_frame_ctrl_if.master       frm,
    output logic [7:0]                drop_cnt_o,
    output logic                      busy_o
);
    localparam int unsigned MEM_AW = ADDR_W + 1;
    localparam int unsigned DEPTH  = 2 ** MEM_AW;
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [ADDR_W-1:0] MIN_L = ADDR_W'(MIN_LEN);
    localparam logic [ADDR_W-1:0] MAX_L = ADDR_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t            state_q;
    logic              dv_q;
    logic              wr_bank_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic              valid_q;
    logic [ADDR_W-1:0] len_q;
    logic              bank_q;
    logic [7:0]        drop_q;
    logic              busy_q;
    logic [7:0]        rd_q;

    logic [7:0] mem [DEPTH];

    logic dv_rise_c, wr_en_c, eof_c, slot_free_c, publish_c, drop_c;

    assign dv_rise_c   = phy1_rx_dv_i && !dv_q;
    assign wr_en_c     = (state_q == DATA) && phy1_rx_dv_i && !phy1_rx_er_i && (wr_ptr_q < MAX_L);
    assign eof_c       = (state_q == DATA) && !phy1_rx_dv_i;
    assign slot_free_c = !valid_q || frm.frame_ack;
    assign publish_c   = eof_c && (wr_ptr_q >= MIN_L) && slot_free_c;

    // Every discard reason; at most one fires per cycle.
    assign drop_c =
        ((state_q == IDLE) && dv_rise_c && (phy1_rx_data_i != PRE_BYTE)) ||
        ((state_q == PRE) && phy1_rx_dv_i &&
            (phy1_rx_er_i || ((phy1_rx_data_i != PRE_BYTE) && (phy1_rx_data_i != SFD_BYTE)))) ||
        ((state_q == DATA) && phy1_rx_dv_i && (phy1_rx_er_i || (wr_ptr_q >= MAX_L))) ||
        (eof_c && !publish_c);

    always_ff @(posedge phy1_rx_clk) begin
        if (wr_en_c) begin
            mem[{wr_bank_q, wr_ptr_q}] <= phy1_rx_data_i;
        end
    end

    always_ff @(posedge phy1_rx_clk) begin
        if (!rst_n) begin
            rd_q <= 8'h00;
        end else begin
            rd_q <= mem[{bank_q, frm.rd_addr}];
        end
    end

    // dv_q resets high so a frame already in flight at reset release is ignored.
    always_ff @(posedge phy1_rx_clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dv_q      <= 1'b1;
            wr_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
            valid_q   <= 1'b0;
            len_q     <= '0;
            bank_q    <= 1'b0;
            drop_q    <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            dv_q <= phy1_rx_dv_i;

            if (drop_c && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            if (publish_c) begin
                valid_q   <= 1'b1;
                len_q     <= wr_ptr_q;
                bank_q    <= wr_bank_q;
                wr_bank_q <= ~wr_bank_q;
            end else if (frm.frame_ack) begin
                valid_q <= 1'b0;
            end

            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (dv_rise_c) begin
                        state_q <= (phy1_rx_data_i == PRE_BYTE) ? PRE : DROP;
                        busy_q  <= 1'b1;
                    end
                end
                PRE: begin
                    if (!phy1_rx_dv_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (phy1_rx_er_i ||
                                 ((phy1_rx_data_i != PRE_BYTE) && (phy1_rx_data_i != SFD_BYTE))) begin
                        state_q <= DROP;
                    end else if (phy1_rx_data_i == SFD_BYTE) begin
                        state_q  <= DATA;
                        wr_ptr_q <= '0;
                    end
                end
                DATA: begin
                    if (!phy1_rx_dv_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (phy1_rx_er_i || (wr_ptr_q >= MAX_L)) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (!phy1_rx_dv_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frm.frame_valid = valid_q;
    assign frm.frame_len   = len_q;
    assign frm.frame_bank  = bank_q;
    assign frm.rd_data     = rd_q;
    assign drop_cnt_o      = drop_q;
    assign busy_o          = busy_q;

endmodule
